// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer slice: FSM state encoding,
// default geometry and the counter-width helper.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    COMPARE,
    DONE
  } bist_state_t;

  localparam int DEF_N = 9;
  localparam int DEF_M = 9;
  localparam int DEF_W = 16;

  // Bits needed to count 0..val-1, never less than one bit.
  function automatic int cnt_width(input int val);
    return (val <= 1) ? 1 : $clog2(val);
  endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// Test-interface and datapath-control bundle between the chip test port,
// the BIST sequencer and the LFSR/scan/MISR datapath.
interface bist_sequencer_if import bist_pkg::*; #(
  parameter int W = DEF_W
);

  logic         START;
  logic         ABORT;
  logic [W-1:0] SIG;
  logic         LFSR_LOAD;
  logic         LFSR_EN;
  logic         SCAN_EN;
  logic         MISR_CLR;
  logic         MISR_EN;
  logic         RUNNING;
  logic         BIST_END;
  logic         PASS;
  logic         FAIL;

  modport master (
    input  START, ABORT, SIG,
    output LFSR_LOAD, LFSR_EN, SCAN_EN, MISR_CLR, MISR_EN,
    output RUNNING, BIST_END, PASS, FAIL
  );

  modport slave (
    output START, ABORT, SIG,
    input  LFSR_LOAD, LFSR_EN, SCAN_EN, MISR_CLR, MISR_EN,
    input  RUNNING, BIST_END, PASS, FAIL
  );

endinterface

// File: rtl/bist_pattern_counter.sv
// Two-level counter: cnt_n walks 0..N within a pattern (N shifts plus one
// capture), cnt_m counts patterns 0..M-1.
module bist_pattern_counter import bist_pkg::*; #(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         clr,
  input  logic                         en,
  output logic [cnt_width(N+1)-1:0]    cnt_n,
  output logic [cnt_width(M)-1:0]      cnt_m,
  output logic                         capture,
  output logic                         last
);

  localparam int NW = cnt_width(N+1);
  localparam int MW = cnt_width(M);
  localparam logic [NW-1:0] N_LAST = NW'(N);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);

  assign capture = (cnt_n == N_LAST);
  assign last    = capture && (cnt_m == M_LAST);

  // Both counters fold back to zero on their terminal values, so they never wrap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_n <= '0;
      cnt_m <= '0;
    end else if (clr) begin
      cnt_n <= '0;
      cnt_m <= '0;
    end else if (en) begin
      if (capture) begin
        cnt_n <= '0;
        cnt_m <= last ? '0 : cnt_m + 1'b1;
      end else begin
        cnt_n <= cnt_n + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// BIST controller: on a START rising edge runs M patterns of N shifts plus a
// capture, then compares the MISR signature against GOLDEN.
module bist_sequencer import bist_pkg::*; #(
  parameter int          N      = DEF_N,
  parameter int          M      = DEF_M,
  parameter int          W      = DEF_W,
  parameter logic [W-1:0] GOLDEN = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  bist_sequencer_if.master  bus
);

  localparam int NW = cnt_width(N+1);
  localparam int MW = cnt_width(M);

  bist_state_t   state;
  bist_state_t   state_nxt;
  logic          start_q;
  logic          start_rise;
  logic          pass_q;
  logic          fail_q;
  logic          cnt_clr;
  logic          cnt_en;
  logic [NW-1:0] cnt_n;
  logic [MW-1:0] cnt_m;
  logic          capture;
  logic          last;
  logic          unused_cnt;

  assign start_rise = bus.START & ~start_q;
  assign unused_cnt = ^{cnt_n, cnt_m};

  bist_pattern_counter #(.N(N), .M(M)) u_counter (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt_n   (cnt_n),
    .cnt_m   (cnt_m),
    .capture (capture),
    .last    (last)
  );

  // start_q resets high so a START already asserted at reset release is not an edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      start_q <= 1'b1;
      state   <= IDLE;
    end else begin
      start_q <= bus.START;
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    case (state)
      IDLE:    if (start_rise) state_nxt = INIT;
      INIT:    state_nxt = bus.ABORT ? IDLE : RUN;
      RUN: begin
        if (bus.ABORT) begin
          state_nxt = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          if (last) state_nxt = COMPARE;
        end
      end
      COMPARE: state_nxt = DONE;
      DONE:    if (start_rise) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
  end

  // The verdict survives a rerun's INIT cycle and is cleared on the way into RUN.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if ((state == INIT) || ((state == RUN) && bus.ABORT)) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (state == COMPARE) begin
      pass_q <= (bus.SIG == GOLDEN);
      fail_q <= (bus.SIG != GOLDEN);
    end
  end

  always_comb begin
    bus.LFSR_LOAD = 1'b0;
    bus.LFSR_EN   = 1'b0;
    bus.SCAN_EN   = 1'b0;
    bus.MISR_CLR  = 1'b0;
    bus.MISR_EN   = 1'b0;
    bus.RUNNING   = 1'b0;
    bus.BIST_END  = 1'b0;
    case (state)
      INIT: begin
        bus.LFSR_LOAD = 1'b1;
        bus.MISR_CLR  = 1'b1;
        bus.RUNNING   = 1'b1;
      end
      RUN: begin
        bus.RUNNING = 1'b1;
        bus.SCAN_EN = ~capture;
        bus.LFSR_EN = ~capture;
        bus.MISR_EN = ~capture;
      end
      DONE:    bus.BIST_END = 1'b1;
      default: ;
    endcase
  end

  assign bus.PASS = pass_q;
  assign bus.FAIL = fail_q;

endmodule
